// File: rtl/mem_req_ctrl_if.sv
// Cache-to-memory-controller bundle: IC/DC line request ports plus the line-granular RAM port.
// master = requesters and RAM model side, slave = mem_req_ctrl.
interface mem_req_ctrl_if;
  logic         ic_req;
  logic [25:0]  ic_addr;
  logic         ic_done;
  logic [127:0] ic_rdata;
  logic         dc_req;
  logic         dc_we;
  logic [25:0]  dc_addr;
  logic [127:0] dc_wdata;
  logic         dc_done;
  logic [127:0] dc_rdata;
  logic         busy;
  logic [25:0]  mem_rd_addr;
  logic [25:0]  mem_wr_addr;
  logic [127:0] mem_wdata;
  logic         mem_we;
  logic [127:0] mem_rdata;

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    input  ic_done, ic_rdata, dc_done, dc_rdata, busy,
           mem_rd_addr, mem_wr_addr, mem_wdata, mem_we
  );

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    output ic_done, ic_rdata, dc_done, dc_rdata, busy,
           mem_rd_addr, mem_wr_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Two-port (IC/DC) line memory request controller: IDLE -> WAIT (LATENCY cycles) -> RESP.
// Define MEM_RR_ARB_EN for round-robin arbitration on ties; default is fixed DC-over-IC priority.
module mem_req_ctrl #(
  parameter int LATENCY = 5
) (
  input  logic          clk,
  input  logic          reset,
  mem_req_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {REQ_IC, REQ_DC} req_id_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e       state_q, state_d;
  req_id_e      id_q, id_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         we_q, we_d;
  logic [25:0]  addr_q, addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic [127:0] ic_rdata_q, ic_rdata_d;
  logic [127:0] dc_rdata_q, dc_rdata_d;
  logic         ic_done_q, ic_done_d;
  logic         dc_done_q, dc_done_d;
  logic         pick_dc;
  logic         in_wait, last_wait;

`ifdef MEM_RR_ARB_EN
  req_id_e last_grant_q, last_grant_d;
  // On a tie the side that did not win last time gets the grant.
  assign pick_dc = bus.dc_req && (!bus.ic_req || last_grant_q == REQ_IC);
`else
  assign pick_dc = bus.dc_req;
`endif

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    ic_done_d  = 1'b0;
    dc_done_d  = 1'b0;
`ifdef MEM_RR_ARB_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.ic_req || bus.dc_req) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          id_d    = pick_dc ? REQ_DC : REQ_IC;
          addr_d  = pick_dc ? bus.dc_addr : bus.ic_addr;
          we_d    = pick_dc && bus.dc_we;
          wdata_d = bus.dc_wdata;
`ifdef MEM_RR_ARB_EN
          last_grant_d = pick_dc ? REQ_DC : REQ_IC;
`endif
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          ic_done_d = (id_q == REQ_IC);
          dc_done_d = (id_q == REQ_DC);
          // Writes leave the requester's rdata untouched.
          if (!we_q) begin
            if (id_q == REQ_DC) dc_rdata_d = bus.mem_rdata;
            else                ic_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      id_q       <= REQ_IC;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      ic_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
`ifdef MEM_RR_ARB_EN
      last_grant_q <= REQ_IC;
`endif
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      ic_done_q  <= ic_done_d;
      dc_done_q  <= dc_done_d;
`ifdef MEM_RR_ARB_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign in_wait   = (state_q == WAIT);
  assign last_wait = in_wait && (cnt_q == 4'd0);

  // mem_we is gated by reset directly so an aborted access never writes.
  assign bus.mem_rd_addr = in_wait ? addr_q : '0;
  assign bus.mem_wr_addr = in_wait ? addr_q : '0;
  assign bus.mem_wdata   = (in_wait && we_q) ? wdata_q : '0;
  assign bus.mem_we      = last_wait && we_q && !reset;
  assign bus.busy        = (state_q != IDLE);
  assign bus.ic_done     = ic_done_q;
  assign bus.dc_done     = dc_done_q;
  assign bus.ic_rdata    = ic_rdata_q;
  assign bus.dc_rdata    = dc_rdata_q;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: vector table + scoreboard on a LATENCY=5 instance, hand sequences
// for ties, reset abort, and a LATENCY=1 instance.
module tb_mem_req_ctrl;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_req_ctrl_if bus();
  mem_req_ctrl_if bus1();

  mem_req_ctrl #(.LATENCY(LAT)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  mem_req_ctrl #(.LATENCY(1))   u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  function automatic logic [127:0] def_line(logic [25:0] a);
    logic [31:0] b;
    b = {6'd0, a} << 2;
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // RAM model: untouched lines read back def_line(addr)
  logic [127:0] wram   [4096];
  bit           wvalid [4096];
  always @(posedge clk)
    if (bus.mem_we) begin
      wram[bus.mem_wr_addr[11:0]]   <= bus.mem_wdata;
      wvalid[bus.mem_wr_addr[11:0]] <= 1'b1;
    end
  assign bus.mem_rdata  = wvalid[bus.mem_rd_addr[11:0]] ? wram[bus.mem_rd_addr[11:0]]
                                                        : def_line(bus.mem_rd_addr);
  assign bus1.mem_rdata = def_line(bus1.mem_rd_addr);

  typedef struct {
    bit           is_dc;
    bit           we;
    logic [127:0] rdata;
  } exp_t;

  typedef struct {
    bit           is_dc;
    bit           we;
    logic [25:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp;
  } vec_t;

  exp_t         sb[$];
  logic [127:0] ic_last, dc_last;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Advance one cycle, sample at the falling edge, retire any done against the scoreboard.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (bus.ic_done || bus.dc_done) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", {bus.ic_done, bus.dc_done}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_port", {bus.ic_done, bus.dc_done}, e.is_dc ? 2'b01 : 2'b10);
        if (!e.we) begin
          if (e.is_dc) dc_last = e.rdata;
          else         ic_last = e.rdata;
        end
        chk("ic_rdata", bus.ic_rdata, ic_last);
        chk("dc_rdata", bus.dc_rdata, dc_last);
      end
    end
  endtask

  task automatic access(vec_t v);
    int we_n = 0;
    bit got  = 1'b0;
    chk("idle_before", bus.busy, 0);
    sb.push_back('{v.is_dc, v.we, v.exp});
    if (v.is_dc) begin
      bus.dc_req = 1'b1; bus.dc_we = v.we; bus.dc_addr = v.addr; bus.dc_wdata = v.wdata;
    end else begin
      bus.ic_req = 1'b1; bus.ic_addr = v.addr;
    end
    for (int k = 1; k <= LAT + 3 && !got; k++) begin
      tick();
      if (k <= LAT) begin
        chk("wait_busy", bus.busy, 1);
        chk("wait_rd_addr", bus.mem_rd_addr, v.addr);
      end
      if (k == 1) begin
        // grant is latched; scramble the buses
        bus.ic_addr  = 26'($urandom);
        bus.dc_addr  = 26'($urandom);
        bus.dc_wdata = {$urandom, $urandom, $urandom, $urandom};
        bus.dc_we    = ~v.we;
      end
      if (bus.mem_we) begin
        we_n++;
        chk("we_cycle", k, LAT);
        chk("wr_addr", bus.mem_wr_addr, v.addr);
        chk("mem_wdata", bus.mem_wdata, v.wdata);
      end
      if (bus.ic_done || bus.dc_done) begin
        got = 1'b1;
        chk("done_latency", k, LAT + 1);
        chk("resp_rd_addr", bus.mem_rd_addr, 0);
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
      end
    end
    chk("done_seen", got, 1);
    chk("we_pulses", we_n, v.we);
    tick();
    chk("done_one_cycle", {bus.ic_done, bus.dc_done}, 0);
  endtask

  vec_t vt[8];

  initial begin
    int ng, done_n, pend;
    bus.ic_req = 0; bus.ic_addr = 0; bus.dc_req = 0; bus.dc_we = 0; bus.dc_addr = 0; bus.dc_wdata = 0;
    bus1.ic_req = 0; bus1.ic_addr = 0; bus1.dc_req = 0; bus1.dc_we = 0; bus1.dc_addr = 0;
    bus1.dc_wdata = 0;
    ic_last = 0; dc_last = 0;

    vt[0] = '{1'b0, 1'b0, 26'h1,   128'h0, def_line(26'h1)};
    vt[1] = '{1'b1, 1'b1, 26'h800, {8{16'hAAAA}}, 128'h0};
    vt[2] = '{1'b1, 1'b0, 26'h800, 128'h0, {8{16'hAAAA}}};
    vt[3] = '{1'b0, 1'b0, 26'h800, 128'h0, {8{16'hAAAA}}};
    vt[4] = '{1'b1, 1'b0, 26'h3,   128'h0, def_line(26'h3)};
    vt[5] = '{1'b1, 1'b1, 26'h5,   128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 128'h0};
    vt[6] = '{1'b0, 1'b0, 26'h5,   128'h0, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321};
    vt[7] = '{1'b1, 1'b0, 26'hfff, 128'h0, def_line(26'hfff)};

    reset = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", {bus.ic_done, bus.dc_done}, 0);
    chk("rst_ic_rdata", bus.ic_rdata, 0);
    chk("rst_dc_rdata", bus.dc_rdata, 0);
    chk("rst_mem_if", {bus.mem_we, bus.mem_rd_addr, bus.mem_wr_addr}, 0);

    // Simultaneous requests straight after reset: DC first, then IC; round-robin re-ties twice.
`ifdef MEM_RR_ARB_EN
    ng = 4;
`else
    ng = 2;
`endif
    for (int j = 0; j < ng; j++)
      sb.push_back('{(j % 2 == 0), 1'b0, (j % 2 == 0) ? def_line(26'h40) : def_line(26'h80)});
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 26'h40;
    bus.ic_req = 1'b1; bus.ic_addr = 26'h80;
    done_n = 0;
    pend   = 0;
    for (int k = 1; k <= ng * (LAT + 2) + 2 && done_n < ng; k++) begin
      tick();
      if (pend == 1) bus.dc_req = 1'b1;
      if (pend == 2) bus.ic_req = 1'b1;
      pend = 0;
      if (bus.ic_done || bus.dc_done) begin
        chk("tie_order_dc", bus.dc_done, (done_n % 2 == 0));
        chk("tie_time", k, (done_n + 1) * (LAT + 2) - 1);
        if (bus.dc_done) bus.dc_req = 1'b0;
        if (bus.ic_done) bus.ic_req = 1'b0;
        if (done_n < ng - 2) pend = bus.dc_done ? 1 : 2;
        done_n++;
      end
    end
    chk("tie_all_done", done_n, ng);
    tick();

    for (int i = 0; i < 8; i++) access(vt[i]);

    // Reset during the final WAIT cycle of a write aborts it.
    bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 26'h900; bus.dc_wdata = {8{16'h5555}};
    for (int k = 1; k < LAT; k++) tick();
    tick();
    chk("abort_we_before", bus.mem_we, 1);
    reset = 1'b1;
    #1;
    chk("abort_we_forced", bus.mem_we, 0);
    tick();
    chk("abort_busy", bus.busy, 0);
    chk("abort_no_done", bus.dc_done, 0);
    reset = 1'b0;
    bus.dc_req = 1'b0;
    ic_last = 0;
    dc_last = 0;
    chk("abort_rdata_clr", {bus.ic_rdata, bus.dc_rdata}, 0);
    access('{1'b1, 1'b0, 26'h900, 128'h0, def_line(26'h900)});

    // LATENCY=1 instance: one WAIT cycle, address change during WAIT ignored.
    bus1.ic_req = 1'b1; bus1.ic_addr = 26'h7;
    tick();
    chk("l1_busy", bus1.busy, 1);
    chk("l1_rd_addr", bus1.mem_rd_addr, 26'h7);
    chk("l1_no_early_done", bus1.ic_done, 0);
    bus1.ic_addr = 26'h9;
    tick();
    chk("l1_done", bus1.ic_done, 1);
    chk("l1_rdata", bus1.ic_rdata, def_line(26'h7));
    bus1.ic_req = 1'b0;
    tick();
    chk("l1_done_pulse", bus1.ic_done, 0);
    chk("l1_idle", bus1.busy, 0);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 5, meaning the number of WAIT cycles per memory access (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port ic_req, input, 1, instruction-cache line read request, held until ic_done.
REQ-005 The block SHALL have port ic_addr, input, 26, instruction-cache line address.
REQ-006 The block SHALL have port ic_done, output, 1, one-cycle pulse; ic_rdata is valid in that cycle.
REQ-007 The block SHALL have port ic_rdata, output, 128, returned instruction line.
REQ-008 The block SHALL have port dc_req, input, 1, data-cache line request, held until dc_done.
REQ-009 The block SHALL have port dc_we, input, 1, 1 = line write, 0 = line read.
REQ-010 The block SHALL have port dc_addr, input, 26, data-cache line address.
REQ-011 The block SHALL have port dc_wdata, input, 128, line to write.
REQ-012 The block SHALL have port dc_done, output, 1, one-cycle pulse; dc_rdata is valid in that cycle for reads.
REQ-013 The block SHALL have port dc_rdata, output, 128, returned data line.
REQ-014 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 The block SHALL have ports mem_rd_addr (output, 26), mem_wr_addr (output, 26), mem_wdata (output, 128), mem_we (output, 1) and mem_rdata (input, 128), forming the line-granular RAM port.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP: IDLE->WAIT on grant, WAIT->RESP when cnt==0, RESP->IDLE unconditionally.
REQ-017 In IDLE, a request SHALL be granted at the clock edge where its req is sampled high; only one request is granted per edge.
REQ-018 On grant, the block SHALL latch the requester ID, address, we and wdata; later changes on input buses SHALL be ignored until done.
REQ-019 On grant, cnt SHALL load LATENCY-1 (4 bits) and decrement once per WAIT cycle.
REQ-020 mem_rd_addr and mem_wr_addr SHALL drive the latched address in every WAIT cycle, and SHALL be 0 otherwise.
REQ-021 mem_we SHALL be high only in the final WAIT cycle (cnt==0) of a granted write, for exactly one cycle, with mem_wdata driving the latched wdata.
REQ-022 For a read, mem_rdata SHALL be captured into the requester's rdata register at the edge leaving the final WAIT cycle.
REQ-023 The done pulse of the granted requester SHALL be high only in RESP, for exactly one cycle: LATENCY+1 cycles after the grant edge.
REQ-024 For writes, dc_rdata SHALL retain its previous value.
REQ-025 ic_rdata and dc_rdata SHALL hold their value until the next completed read to that port.
REQ-026 A requester SHALL deassert req at the edge that samples its done; a req seen in IDLE after RESP SHALL be treated as a new request.
REQ-027 A req that rises while busy SHALL wait and be granted at the first IDLE edge.
REQ-028 Back-to-back accesses SHALL therefore have a spacing of LATENCY+2 cycles.

Reset
REQ-029 While reset is high at an edge, the block SHALL go to IDLE, clear cnt, done, busy and rdata registers to 0, and clear last_grant to IC.
REQ-030 While reset is high, mem_we SHALL be forced to 0 combinationally, so an access in progress is aborted with no write and no done pulse.

Configuration
REQ-031 Without MEM_RR_ARB_EN, arbitration SHALL use fixed priority: dc_req beats ic_req.
REQ-032 With MEM_RR_ARB_EN defined, arbitration SHALL be round-robin on simultaneous requests: the requester not equal to last_grant wins, and last_grant updates on every grant (after reset, DC wins the first tie).

Verification
REQ-033 Scenario: LATENCY=5; ic_req with ic_addr=0x0000001, RAM line 1 = 0x...0007_0006_0005_0004 -> ic_done is high exactly 6 cycles after the grant edge, with ic_rdata equal to that line.
REQ-034 Scenario: dc write to addr 0x0000800 with data 0xAAAA...AAAA -> mem_we high for 1 cycle (5th WAIT cycle) with mem_wr_addr=0x800; a following dc read of 0x800 returns 0xAAAA...AAAA.
REQ-035 Scenario: ic_req and dc_req rise in the same cycle, macro undefined -> DC granted first and IC granted at the edge 7 cycles later; macro defined with two repeated ties -> grants alternate DC, IC, DC, IC.
REQ-036 Scenario: reset asserted during the final WAIT cycle of a write -> mem_we stays 0, no dc_done, and busy=0 after the edge.
REQ-037 Scenario: LATENCY=1 with a read -> one WAIT cycle and done 2 cycles after the grant edge; ic_addr changed during WAIT -> the original line is returned.
